// File: rtl/regs.sv
// 32 x 32-bit RISC-V register file with a one-entry write-back register,
// two bypassed combinational decode read ports and a registered debug port.
module regs #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  localparam int AW     = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_wen_i,
  input  logic [AW-1:0]     reg1_raddr_i,
  input  logic [AW-1:0]     reg2_raddr_i,
  output logic [DATA_W-1:0] reg1_rdata_o,
  output logic [DATA_W-1:0] reg2_rdata_o,
  input  logic [AW-1:0]     dbg_raddr_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              wb_pending_o
);

  logic [DATA_W-1:0] reg_array [REG_NUM];
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              capture;
  logic [DATA_W-1:0] arr1, arr2, arr_dbg;
  logic [DATA_W-1:0] dbg_next;

  assign capture = rd_wen_i && (rd_addr_i != '0);

  // Newest-value selection: x0, then the ex write this cycle, then the
  // write-back register, and only then the committed array contents.
  function automatic logic [DATA_W-1:0] newest(
    input logic [AW-1:0]     addr,
    input logic [DATA_W-1:0] arr_val,
    input logic              ex_wen,
    input logic [AW-1:0]     ex_addr,
    input logic [DATA_W-1:0] ex_data,
    input logic              wbv,
    input logic [AW-1:0]     wba,
    input logic [DATA_W-1:0] wbd
  );
    if (addr == '0)
      return '0;
    else if (ex_wen && ex_addr == addr)
      return ex_data;
    else if (wbv && wba == addr)
      return wbd;
    else
      return arr_val;
  endfunction

  assign arr1    = reg_array[reg1_raddr_i];
  assign arr2    = reg_array[reg2_raddr_i];
  assign arr_dbg = reg_array[dbg_raddr_i];

  always_comb begin
    reg1_rdata_o = newest(reg1_raddr_i, arr1, rd_wen_i, rd_addr_i, rd_data_i,
                          wb_valid, wb_addr, wb_data);
    reg2_rdata_o = newest(reg2_raddr_i, arr2, rd_wen_i, rd_addr_i, rd_data_i,
                          wb_valid, wb_addr, wb_data);
    dbg_next     = newest(dbg_raddr_i, arr_dbg, rd_wen_i, rd_addr_i, rd_data_i,
                          wb_valid, wb_addr, wb_data);
  end

  // Capture and commit share an edge; the older entry always commits first,
  // so same-address back-to-back writes retire in program order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++)
        reg_array[i] <= '0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      dbg_rdata_o <= '0;
    end else begin
      wb_valid <= capture;
      if (capture) begin
        wb_addr <= rd_addr_i;
        wb_data <= rd_data_i;
      end
      if (wb_valid)
        reg_array[wb_addr] <= wb_data;
      dbg_rdata_o <= dbg_next;
    end
  end

  assign wb_pending_o = wb_valid;

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: a newest-value register model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic [31:0] rd_data_i = '0;
  logic        rd_wen_i = 1'b0;
  logic [4:0]  reg1_raddr_i = '0;
  logic [4:0]  reg2_raddr_i = '0;
  logic [31:0] reg1_rdata_o;
  logic [31:0] reg2_rdata_o;
  logic [4:0]  dbg_raddr_i = '0;
  logic [31:0] dbg_rdata_o;
  logic        wb_pending_o;

  int passCount = 0;
  int checkCount = 0;
  bit checkEn = 1'b0;

  // Architectural view: latest value of every register in program order.
  logic [31:0] modelVal [32];
  logic        modelPend;
  logic [31:0] modelDbg;

  regs dut (
    .clk(clk),
    .rst(rst),
    .rd_addr_i(rd_addr_i),
    .rd_data_i(rd_data_i),
    .rd_wen_i(rd_wen_i),
    .reg1_raddr_i(reg1_raddr_i),
    .reg2_raddr_i(reg2_raddr_i),
    .reg1_rdata_o(reg1_rdata_o),
    .reg2_rdata_o(reg2_rdata_o),
    .dbg_raddr_i(dbg_raddr_i),
    .dbg_rdata_o(dbg_rdata_o),
    .wb_pending_o(wb_pending_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] latest(input logic [4:0] a);
    if (a == 5'd0)
      return 32'd0;
    if (rd_wen_i && rd_addr_i == a)
      return rd_data_i;
    return modelVal[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        modelVal[i] <= 32'd0;
      modelPend <= 1'b0;
      modelDbg  <= 32'd0;
    end else begin
      modelDbg  <= latest(dbg_raddr_i);
      modelPend <= rd_wen_i && rd_addr_i != 5'd0;
      if (rd_wen_i && rd_addr_i != 5'd0)
        modelVal[rd_addr_i] <= rd_data_i;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model reg1", reg1_rdata_o, latest(reg1_raddr_i));
      checkOutput("model reg2", reg2_rdata_o, latest(reg2_raddr_i));
      checkOutput("model pending", {31'd0, wb_pending_o}, {31'd0, modelPend});
      checkOutput("model dbg", dbg_rdata_o, modelDbg);
    end
  end

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic wen, input logic [4:0] addr,
                               input logic [31:0] data, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] dbg);
    @(posedge clk);
    #1;
    rd_wen_i     = wen;
    rd_addr_i    = addr;
    rd_data_i    = data;
    reg1_raddr_i = r1;
    reg2_raddr_i = r2;
    dbg_raddr_i  = dbg;
    @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b1;
    checkEn = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic write/read of x3
    applyStimulus(1'b1, 5'd3, 32'h0000_00AA, 5'd3, 5'd3, 5'd3);
    checkOutput("basic bypass N", reg1_rdata_o, 32'h0000_00AA);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 5'd3);
    checkOutput("basic wb N+1", reg1_rdata_o, 32'h0000_00AA);
    checkOutput("basic pending N+1", {31'd0, wb_pending_o}, 32'd1);
    checkOutput("basic dbg N+1", dbg_rdata_o, 32'h0000_00AA);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 5'd3);
    checkOutput("basic array N+2", reg1_rdata_o, 32'h0000_00AA);
    checkOutput("basic pending N+2", {31'd0, wb_pending_o}, 32'd0);

    // x0 protection
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    checkOutput("x0 reg1 same cycle", reg1_rdata_o, 32'd0);
    checkOutput("x0 reg2 same cycle", reg2_rdata_o, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0 pending", {31'd0, wb_pending_o}, 32'd0);
    checkOutput("x0 dbg", dbg_rdata_o, 32'd0);

    // Back-to-back hazard on x7
    applyStimulus(1'b1, 5'd7, 32'd1, 5'd7, 5'd7, 5'd0);
    checkOutput("hazard N reg1", reg1_rdata_o, 32'd1);
    checkOutput("hazard N reg2", reg2_rdata_o, 32'd1);
    applyStimulus(1'b1, 5'd7, 32'd2, 5'd7, 5'd7, 5'd0);
    checkOutput("hazard N+1 reg1", reg1_rdata_o, 32'd2);
    checkOutput("hazard N+1 reg2", reg2_rdata_o, 32'd2);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd0);
    checkOutput("hazard N+2 reg1", reg1_rdata_o, 32'd2);
    checkOutput("hazard N+2 reg2", reg2_rdata_o, 32'd2);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd7);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    checkOutput("hazard dbg N+4", dbg_rdata_o, 32'd2);

    // Independent ports
    applyStimulus(1'b1, 5'd1, 32'd10, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd2, 32'd20, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd2, 32'd30, 5'd1, 5'd2, 5'd0);
    checkOutput("indep reg1", reg1_rdata_o, 32'd10);
    checkOutput("indep reg2", reg2_rdata_o, 32'd30);

    // Reset with a write pending
    applyStimulus(1'b1, 5'd5, 32'd55, 5'd5, 5'd5, 5'd5);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
    checkOutput("pre-reset pending", {31'd0, wb_pending_o}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("reset pending async", {31'd0, wb_pending_o}, 32'd0);
    checkOutput("reset dbg async", dbg_rdata_o, 32'd0);
    checkOutput("reset reg1 x5", reg1_rdata_o, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
    checkOutput("post-reset x5", reg1_rdata_o, 32'd0);
    checkOutput("post-reset dbg", dbg_rdata_o, 32'd0);

    // Fill x1..x31 then sweep the debug port over all 32 registers
    for (int i = 1; i < 32; i++)
      applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'(i - 1), 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 33; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'(i));
      if (i > 0)
        checkOutput($sformatf("sweep x%0d", i - 1), dbg_rdata_o,
                    (i == 1) ? 32'd0 : 32'h100 + 32'(i - 1));
    end

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regs.md
# regs

General-purpose register file for the phase-1 RISC-V core: 32 × 32-bit architectural registers, x0 hard-wired to zero. It receives write-backs from the execute stage (`rd_addr`, `rd_data`, `rd_wen`) through an internal one-entry write-back register. It serves two combinational read ports to the decode stage, with full bypassing so decode always sees the newest value. A registered debug read port gives testbench and debugger access without disturbing the pipeline.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers; address width is log2(`REG_NUM`) = 5.
- `DATA_W`, 32: register width.

Ports (clock and reset first):
- `clk`  input  1  core clock; all state updates on rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `rd_addr_i`  input  5  write address from ex.
- `rd_data_i`  input  32  write data from ex.
- `rd_wen_i`  input  1  write enable from ex.
- `reg1_raddr_i`  input  5  decode read port 1 address.
- `reg2_raddr_i`  input  5  decode read port 2 address.
- `reg1_rdata_o`  output  32  read port 1 data (combinational).
- `reg2_rdata_o`  output  32  read port 2 data (combinational).
- `dbg_raddr_i`  input  5  debug read address.
- `dbg_rdata_o`  output  32  debug read data (registered).
- `wb_pending_o`  output  1  write-back register holds an uncommitted write.

## Operation
- Write-back register: fields `wb_addr`, `wb_data`, and `wb_valid`.
- Capture rule: on each edge, `wb_valid` <= `rd_wen_i` && (`rd_addr_i` != 0). When that is true, the edge also captures `wb_addr` and `wb_data`. Writes to x0 are dropped here and never reach the array.
- Commit rule: on each edge where `wb_valid` = 1 (value before the edge), the edge writes `wb_data` into `regs[wb_addr]`.
- Capture and commit happen on the same edge without conflict. If both target the same address, the older entry commits now and the newer one commits on the following edge. Program order is preserved.
- Read priority for each decode port, evaluated independently per port:
  - 1. address == 0 → 0.
  - 2. `rd_wen_i` && `rd_addr_i` == address → `rd_data_i`.
  - 3. `wb_valid` && `wb_addr` == address → `wb_data`.
  - 4. otherwise → `regs[address]`.
- Debug port: on each edge, `dbg_rdata_o` <= the value the same priority chain produces for `dbg_raddr_i`.
- `wb_pending_o` = `wb_valid`.
- No stall or backpressure: the block accepts one write every cycle, unconditionally.

## Timing
- Reset (asynchronous, while `rst` = 1), regardless of `clk`:
  - all 32 array entries = 0;
  - `wb_valid` = 0, `wb_addr` = 0, `wb_data` = 0;
  - `dbg_rdata_o` = 0;
  - `wb_pending_o` = 0.
  - While reset is held, decode read ports return 0 for every address unless the same-cycle ex bypass (priority 2) matches.
- Reset asserted mid-operation discards any pending write-back; it is not committed.
- Write latency, for an ex write presented in cycle N:
  - visible on decode ports in cycle N (bypass);
  - held in the write-back register from the edge ending N;
  - in the array from the edge ending N+1.
- Read latency: decode ports 0 cycles. Debug port 1 cycle (the address presented in cycle N produces data in N+1).
- Back-to-back writes to the same register in N and N+1: a read in N+1 returns the N+1 data (priority 2 beats priority 3). The array ends up holding the N+1 data.
- Writes with `rd_wen_i` = 0 cause no state change, whatever the address or data.

## Test plan
- Reset: drive `rst` = 1 mid-simulation with a write pending. Then:
  - `wb_pending_o` = 0 immediately, without waiting for a clock edge;
  - after release, reading x5 returns 0;
  - `dbg_rdata_o` = 0.
- Basic write/read: write x3 = 32'h0000_00AA in cycle N. Require:
  - `reg1_rdata_o` = AA in N (bypass);
  - AA in N+1 via the write-back register;
  - AA in N+2 from the array, with `wb_pending_o` = 0 in N+2.
- x0 protection: write x0 = 32'hFFFF_FFFF. Require:
  - both ports return 0 when addressed to x0, including in the same cycle;
  - `wb_pending_o` remains 0;
  - debug read of x0 returns 0.
- Back-to-back hazard: write x7 = 1 in N, then x7 = 2 in N+1, with both read ports on x7. Require:
  - reads = 1 in N;
  - reads = 2 in N+1 and in N+2;
  - debug read of x7 issued in N+3 returns 2 in N+4.
- Independent ports: x1 = 10 and x2 = 20 already committed. Write x2 = 30 in the same cycle that port 1 reads x1 and port 2 reads x2. Require `reg1_rdata_o` = 10 and `reg2_rdata_o` = 30.
- Fill/sweep: write every register x1..x31 with value (0x100 + index) on consecutive cycles. Then debug-read all 32 registers and require x0 = 0 and xi = 0x100 + i.
